// File: rtl/tlb_multiport_pkg.sv
// Shared types for the multi-port TLB: per-cycle update operation and fill target kind.
package tlb_multiport_pkg;

  // Update operation applied to the entry array on a given edge.
  typedef enum logic [1:0] {
    OP_IDLE,
    OP_FILL,
    OP_INV,
    OP_FLUSH
  } op_e;

  // How a fill picks its target entry.
  typedef enum logic [1:0] {
    FILL_NONE,
    FILL_UPDATE,   // entry already holds the VPN: overwrite in place
    FILL_FREE,     // lowest-index invalid entry
    FILL_REPLACE   // array full: round-robin victim
  } fill_kind_e;

  // Flush beats invalidate, invalidate beats fill.
  function automatic op_e op_select(input logic flush, input logic inv, input logic fill);
    if (flush) begin
      return OP_FLUSH;
    end
    if (inv) begin
      return OP_INV;
    end
    if (fill) begin
      return OP_FILL;
    end
    return OP_IDLE;
  endfunction

endpackage

// File: rtl/tlb_multiport_match.sv
// Combinational VPN compare of one address against every entry: one-hot hit vector
// plus the attributes of the matching entry. Entries never hold duplicate VPNs, so
// the AND-OR mux below is exact.
module tlb_match
  import tlb_multiport_pkg::*;
#(
  parameter int unsigned ENTRIES = 8,
  parameter int unsigned VPN_W   = 20,
  parameter int unsigned PFN_W   = 20
) (
  input  logic [VPN_W-1:0]              vpn,
  input  logic [ENTRIES-1:0]            ent_valid,
  input  logic [ENTRIES-1:0][VPN_W-1:0] ent_vpn,
  input  logic [ENTRIES-1:0][PFN_W-1:0] ent_pfn,
  input  logic [ENTRIES-1:0]            ent_rw,
  input  logic [ENTRIES-1:0]            ent_pcd,
  output logic [ENTRIES-1:0]            hit_vec,
  output logic [PFN_W-1:0]              pfn,
  output logic                          rw,
  output logic                          pcd
);

  // Compare against all valid entries and OR together the selected entry's fields.
  always_comb begin
    hit_vec = '0;
    pfn     = '0;
    rw      = 1'b0;
    pcd     = 1'b0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      hit_vec[i] = ent_valid[i] && (ent_vpn[i] == vpn);
      if (hit_vec[i]) begin
        pfn = pfn | ent_pfn[i];
        rw  = rw  | ent_rw[i];
        pcd = pcd | ent_pcd[i];
      end
    end
  end

endmodule

// File: rtl/tlb_multiport.sv
// Fully-associative, multi-port TLB with registered lookup results, fill,
// single-VPN invalidate and full flush.
module tlb_multiport
  import tlb_multiport_pkg::*;
#(
  parameter int unsigned ENTRIES   = 8,
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned VA_W      = 32,
  parameter int unsigned PA_W      = 32,
  parameter int unsigned PAGE_BITS = 12
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          lk_valid,
  input  logic [NUM_PORTS*VA_W-1:0]     lk_va,
  output logic [NUM_PORTS-1:0]          lk_done,
  output logic [NUM_PORTS-1:0]          lk_hit,
  output logic [NUM_PORTS*PA_W-1:0]     lk_pa,
  output logic [NUM_PORTS-1:0]          lk_rw,
  output logic [NUM_PORTS-1:0]          lk_pcd,
  input  logic                          fill_valid,
  output logic                          fill_ready,
  input  logic [VA_W-PAGE_BITS-1:0]     fill_vpn,
  input  logic [PA_W-PAGE_BITS-1:0]     fill_pfn,
  input  logic                          fill_rw,
  input  logic                          fill_pcd,
  input  logic                          inv_valid,
  input  logic [VA_W-PAGE_BITS-1:0]     inv_vpn,
  input  logic                          flush,
  output logic [$clog2(ENTRIES+1)-1:0]  occupancy
);

  localparam int unsigned VPN_W = VA_W - PAGE_BITS;
  localparam int unsigned PFN_W = PA_W - PAGE_BITS;
  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned OCC_W = $clog2(ENTRIES + 1);

  logic [ENTRIES-1:0]            ent_valid;
  logic [ENTRIES-1:0][VPN_W-1:0] ent_vpn;
  logic [ENTRIES-1:0][PFN_W-1:0] ent_pfn;
  logic [ENTRIES-1:0]            ent_rw;
  logic [ENTRIES-1:0]            ent_pcd;
  logic [IDX_W-1:0]              rr_ptr;
  logic [OCC_W-1:0]              occ_q;

  op_e                           op;
  fill_kind_e                    fill_kind;
  logic [VPN_W-1:0]              upd_vpn;
  logic [ENTRIES-1:0]            upd_hit_vec;
  logic [PFN_W-1:0]              upd_pfn;
  logic                          upd_rw;
  logic                          upd_pcd;
  logic [ENTRIES-1:0]            free_vec;
  logic [ENTRIES-1:0]            wr_vec;
  logic [ENTRIES-1:0]            valid_n;
  logic [IDX_W-1:0]              rr_n;
  logic [OCC_W-1:0]              occ_n;

  assign fill_ready = !flush && !inv_valid;
  assign op         = op_select(flush, inv_valid, fill_valid);
  assign occupancy  = occ_q;

  // Invalidate and fill never act in the same cycle, so they share one compare path.
  assign upd_vpn = inv_valid ? inv_vpn : fill_vpn;

  tlb_match #(
    .ENTRIES (ENTRIES),
    .VPN_W   (VPN_W),
    .PFN_W   (PFN_W)
  ) u_upd_match (
    .vpn       (upd_vpn),
    .ent_valid (ent_valid),
    .ent_vpn   (ent_vpn),
    .ent_pfn   (ent_pfn),
    .ent_rw    (ent_rw),
    .ent_pcd   (ent_pcd),
    .hit_vec   (upd_hit_vec),
    .pfn       (upd_pfn),
    .rw        (upd_rw),
    .pcd       (upd_pcd)
  );

  // Lowest-index invalid entry as a one-hot vector (all zero when the array is full).
  always_comb begin
    logic found;
    free_vec = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!ent_valid[i] && !found) begin
        free_vec[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  // Classify a fill: in-place update, free slot, or round-robin replacement.
  always_comb begin
    fill_kind = FILL_NONE;
    if (op == OP_FILL) begin
      if (|upd_hit_vec) begin
        fill_kind = FILL_UPDATE;
      end else if (|free_vec) begin
        fill_kind = FILL_FREE;
      end else begin
        fill_kind = FILL_REPLACE;
      end
    end
  end

  // Next valid vector, write enables, replacement pointer and occupancy.
  always_comb begin
    valid_n = ent_valid;
    wr_vec  = '0;
    rr_n    = rr_ptr;
    case (fill_kind)
      FILL_UPDATE:  wr_vec = upd_hit_vec;
      FILL_FREE:    wr_vec = free_vec;
      FILL_REPLACE: begin
        wr_vec = ENTRIES'(1) << rr_ptr;
        rr_n   = (rr_ptr == IDX_W'(ENTRIES - 1)) ? '0 : rr_ptr + 1'b1;
      end
      default:      wr_vec = '0;
    endcase
    case (op)
      OP_FLUSH: begin
        valid_n = '0;
        rr_n    = '0;
      end
      OP_INV:   valid_n = ent_valid & ~upd_hit_vec;
      OP_FILL:  valid_n = ent_valid | wr_vec;
      default:  valid_n = ent_valid;
    endcase
    occ_n = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      occ_n = occ_n + OCC_W'(valid_n[i]);
    end
  end

  // Entry array, replacement pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_valid <= '0;
      ent_vpn   <= '0;
      ent_pfn   <= '0;
      ent_rw    <= '0;
      ent_pcd   <= '0;
      rr_ptr    <= '0;
      occ_q     <= '0;
    end else begin
      ent_valid <= valid_n;
      rr_ptr    <= rr_n;
      occ_q     <= occ_n;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        if (wr_vec[i]) begin
          ent_vpn[i] <= fill_vpn;
          ent_pfn[i] <= fill_pfn;
          ent_rw[i]  <= fill_rw;
          ent_pcd[i] <= fill_pcd;
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [VPN_W-1:0]     q_vpn;
    logic [PAGE_BITS-1:0] q_off;
    logic [ENTRIES-1:0]   m_hit_vec;
    logic [PFN_W-1:0]     m_pfn;
    logic                 m_rw;
    logic                 m_pcd;
    logic                 done_q;
    logic                 hit_q;
    logic                 rw_q;
    logic                 pcd_q;
    logic [PA_W-1:0]      pa_q;

    assign q_vpn = lk_va[p*VA_W+PAGE_BITS +: VPN_W];
    assign q_off = lk_va[p*VA_W +: PAGE_BITS];

    tlb_match #(
      .ENTRIES (ENTRIES),
      .VPN_W   (VPN_W),
      .PFN_W   (PFN_W)
    ) u_lk_match (
      .vpn       (q_vpn),
      .ent_valid (ent_valid),
      .ent_vpn   (ent_vpn),
      .ent_pfn   (ent_pfn),
      .ent_rw    (ent_rw),
      .ent_pcd   (ent_pcd),
      .hit_vec   (m_hit_vec),
      .pfn       (m_pfn),
      .rw        (m_rw),
      .pcd       (m_pcd)
    );

    // Register one lookup result per request; all fields are zero unless done and hit.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        done_q <= 1'b0;
        hit_q  <= 1'b0;
        rw_q   <= 1'b0;
        pcd_q  <= 1'b0;
        pa_q   <= '0;
      end else begin
        done_q <= lk_valid[p];
        if (lk_valid[p] && |m_hit_vec) begin
          hit_q <= 1'b1;
          rw_q  <= m_rw;
          pcd_q <= m_pcd;
          pa_q  <= {m_pfn, q_off};
        end else begin
          hit_q <= 1'b0;
          rw_q  <= 1'b0;
          pcd_q <= 1'b0;
          pa_q  <= '0;
        end
      end
    end

    assign lk_done[p]              = done_q;
    assign lk_hit[p]               = hit_q;
    assign lk_rw[p]                = rw_q;
    assign lk_pcd[p]               = pcd_q;
    assign lk_pa[p*PA_W +: PA_W]   = pa_q;
  end

endmodule

// File: tb/tb_tlb_multiport.sv
// Self-checking bench for tlb_multiport: behavioural model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_tlb_multiport;

  localparam int NE = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  lk_valid = '0;
  logic [63:0] lk_va = '0;
  logic [1:0]  lk_done, lk_hit, lk_rw, lk_pcd;
  logic [63:0] lk_pa;
  logic        fill_valid = 1'b0;
  logic        fill_ready;
  logic [19:0] fill_vpn = '0;
  logic [19:0] fill_pfn = '0;
  logic        fill_rw = 1'b0;
  logic        fill_pcd = 1'b0;
  logic        inv_valid = 1'b0;
  logic [19:0] inv_vpn = '0;
  logic        flush = 1'b0;
  logic [3:0]  occupancy;

  int passed = 0;
  int total  = 0;

  tlb_multiport #(
    .ENTRIES   (8),
    .NUM_PORTS (2),
    .VA_W      (32),
    .PA_W      (32),
    .PAGE_BITS (12)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .lk_valid   (lk_valid),
    .lk_va      (lk_va),
    .lk_done    (lk_done),
    .lk_hit     (lk_hit),
    .lk_pa      (lk_pa),
    .lk_rw      (lk_rw),
    .lk_pcd     (lk_pcd),
    .fill_valid (fill_valid),
    .fill_ready (fill_ready),
    .fill_vpn   (fill_vpn),
    .fill_pfn   (fill_pfn),
    .fill_rw    (fill_rw),
    .fill_pcd   (fill_pcd),
    .inv_valid  (inv_valid),
    .inv_vpn    (inv_vpn),
    .flush      (flush),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a table of translations plus the round-robin victim counter.
  bit        m_valid[NE];
  bit [19:0] m_vpn[NE];
  bit [19:0] m_pfn[NE];
  bit        m_rw[NE];
  bit        m_pcd[NE];
  int        m_rr;

  function automatic int m_find(input bit [19:0] vpn);
    for (int i = 0; i < NE; i++) begin
      if (m_valid[i] && m_vpn[i] == vpn) return i;
    end
    return -1;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NE; i++) c += int'(m_valid[i]);
    return c;
  endfunction

  logic [1:0]  e_done, e_hit, e_rw, e_pcd;
  logic [63:0] e_pa;

  // Compare process: predict this edge's results from the pre-edge model, update the
  // model, then check the DUT shortly after the edge.
  always @(posedge clk) begin
    chk("fill_ready", {63'd0, fill_ready}, {63'd0, !flush && !inv_valid});
    e_done = '0; e_hit = '0; e_rw = '0; e_pcd = '0; e_pa = '0;
    if (reset) begin
      for (int i = 0; i < NE; i++) m_valid[i] = 1'b0;
      m_rr = 0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        logic [31:0] va;
        int idx;
        va = lk_va[p*32 +: 32];
        idx = m_find(va[31:12]);
        e_done[p] = lk_valid[p];
        if (lk_valid[p] && idx >= 0) begin
          e_hit[p] = 1'b1;
          e_rw[p]  = m_rw[idx];
          e_pcd[p] = m_pcd[idx];
          e_pa[p*32 +: 32] = {m_pfn[idx], va[11:0]};
        end
      end
      if (flush) begin
        for (int i = 0; i < NE; i++) m_valid[i] = 1'b0;
        m_rr = 0;
      end else if (inv_valid) begin
        int idx;
        idx = m_find(inv_vpn);
        if (idx >= 0) m_valid[idx] = 1'b0;
      end else if (fill_valid) begin
        int idx;
        idx = m_find(fill_vpn);
        if (idx < 0) begin
          for (int i = NE - 1; i >= 0; i--) begin
            if (!m_valid[i]) idx = i;
          end
        end
        if (idx < 0) begin
          idx = m_rr;
          m_rr = (m_rr + 1) % NE;
        end
        m_valid[idx] = 1'b1;
        m_vpn[idx]   = fill_vpn;
        m_pfn[idx]   = fill_pfn;
        m_rw[idx]    = fill_rw;
        m_pcd[idx]   = fill_pcd;
      end
    end
    #1;
    chk("lk_done", {62'd0, lk_done}, {62'd0, e_done});
    chk("lk_hit",  {62'd0, lk_hit},  {62'd0, e_hit});
    chk("lk_rw",   {62'd0, lk_rw},   {62'd0, e_rw});
    chk("lk_pcd",  {62'd0, lk_pcd},  {62'd0, e_pcd});
    chk("lk_pa",   lk_pa, e_pa);
    chk("occupancy", {60'd0, occupancy}, 64'(m_count()));
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_fill(input logic [19:0] vpn, input logic [19:0] pfn,
                         input logic rw, input logic pcd);
    fill_valid = 1'b1;
    fill_vpn   = vpn;
    fill_pfn   = pfn;
    fill_rw    = rw;
    fill_pcd   = pcd;
    cyc();
    fill_valid = 1'b0;
  endtask

  task automatic lookup(input logic [1:0] v, input logic [31:0] va0, input logic [31:0] va1);
    lk_valid = v;
    lk_va    = {va1, va0};
    cyc();
    lk_valid = '0;
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;

    // 1: lookup on empty array misses
    lookup(2'b01, 32'h00403123, 32'h0);
    chk("t1_done", {62'd0, lk_done}, 64'h1);
    chk("t1_hit", {62'd0, lk_hit}, 64'h0);
    chk("t1_pa", lk_pa, 64'h0);
    chk("t1_occ", {60'd0, occupancy}, 64'd0);

    // 2: fill then dual-port hit
    do_fill(20'h00403, 20'h12345, 1'b1, 1'b0);
    lookup(2'b11, 32'h00403ABC, 32'h00403ABC);
    chk("t2_hit", {62'd0, lk_hit}, 64'h3);
    chk("t2_pa", lk_pa, 64'h12345ABC_12345ABC);
    chk("t2_rw", {62'd0, lk_rw}, 64'h3);

    // 3: fill eight, then replacement in round-robin order
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    for (int i = 0; i < 8; i++) do_fill(20'h100 + 20'(i), 20'h50100 + 20'(i), 1'b0, 1'b0);
    chk("t3_occ8", {60'd0, occupancy}, 64'd8);
    do_fill(20'h108, 20'h50108, 1'b1, 1'b0);
    lookup(2'b11, 32'h00100000, 32'h00108000);
    chk("t3_victim0", {62'd0, lk_hit}, 64'h2);
    chk("t3_occ", {60'd0, occupancy}, 64'd8);
    do_fill(20'h109, 20'h50109, 1'b0, 1'b0);
    lookup(2'b11, 32'h00101000, 32'h00108000);
    chk("t3_victim1", {62'd0, lk_hit}, 64'h2);

    // 4: refill existing VPN
    do_fill(20'h105, 20'h00ABC, 1'b0, 1'b1);
    chk("t4_occ", {60'd0, occupancy}, 64'd8);
    lookup(2'b01, 32'h00105FFF, 32'h0);
    chk("t4_pa", lk_pa, 64'h00000000_00ABCFFF);
    chk("t4_pcd", {62'd0, lk_pcd}, 64'h1);

    // 5: invalidate wins over a same-cycle fill; fill taken next cycle
    fill_valid = 1'b1; fill_vpn = 20'h200; fill_pfn = 20'h77777; fill_rw = 1'b1; fill_pcd = 1'b0;
    inv_valid = 1'b1; inv_vpn = 20'h102;
    #1;
    chk("t5_ready0", {63'd0, fill_ready}, 64'd0);
    cyc();
    inv_valid = 1'b0;
    #1;
    chk("t5_ready1", {63'd0, fill_ready}, 64'd1);
    chk("t5_occ7", {60'd0, occupancy}, 64'd7);
    cyc();
    fill_valid = 1'b0;
    lookup(2'b11, 32'h00102000, 32'h00200123);
    chk("t5_hit", {62'd0, lk_hit}, 64'h2);
    chk("t5_pa", lk_pa, 64'h77777123_00000000);
    chk("t5_occ8", {60'd0, occupancy}, 64'd8);

    // 6: lookup alongside flush sees old data; next lookup misses
    flush = 1'b1;
    lookup(2'b01, 32'h00105000, 32'h0);
    flush = 1'b0;
    chk("t6_old_hit", {62'd0, lk_hit}, 64'h1);
    chk("t6_old_pa", lk_pa, 64'h00000000_00ABC000);
    chk("t6_occ", {60'd0, occupancy}, 64'd0);
    lookup(2'b01, 32'h00105000, 32'h0);
    chk("t6_miss", {62'd0, lk_hit}, 64'h0);
    chk("t6_done", {62'd0, lk_done}, 64'h1);

    // 7: reset asserted with lookups in flight
    do_fill(20'h321, 20'h11111, 1'b1, 1'b1);
    lk_valid = 2'b11;
    lk_va = {32'h00321000, 32'h00321000};
    cyc();
    chk("t7_pre_done", {62'd0, lk_done}, 64'h3);
    reset = 1'b1;
    #1;
    chk("t7_done", {62'd0, lk_done}, 64'h0);
    chk("t7_hit", {62'd0, lk_hit}, 64'h0);
    chk("t7_pa", lk_pa, 64'h0);
    chk("t7_occ", {60'd0, occupancy}, 64'd0);
    cyc();
    cyc();
    chk("t7_hold_done", {62'd0, lk_done}, 64'h0);
    reset = 1'b0;
    lk_valid = '0;
    cyc();

    // Randomized traffic over a small VPN pool so hits, replacements and invalidates mix.
    for (int n = 0; n < 600; n++) begin
      lk_valid   = 2'($urandom_range(0, 3));
      lk_va      = {20'h300 + 20'($urandom_range(0, 11)), 12'($urandom),
                    20'h300 + 20'($urandom_range(0, 11)), 12'($urandom)};
      fill_valid = ($urandom_range(0, 9) < 4);
      fill_vpn   = 20'h300 + 20'($urandom_range(0, 11));
      fill_pfn   = 20'($urandom);
      fill_rw    = 1'($urandom);
      fill_pcd   = 1'($urandom);
      inv_valid  = ($urandom_range(0, 9) < 2);
      inv_vpn    = 20'h300 + 20'($urandom_range(0, 11));
      flush      = ($urandom_range(0, 49) == 0);
      cyc();
    end
    lk_valid = '0; fill_valid = 1'b0; inv_valid = 1'b0; flush = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
